inst_mem_loader: RTL

Byte-stream program loader that writes the instruction memory from the host side, while the CPU only ever reads it. Accepts a framed byte stream over a valid/ready handshake and packs bytes into 32-bit instruction words. Writes each word to the instruction memory write port at the byte address the CPU fetch path uses (word index × 4). Holds the CPU in reset until a complete, checksum-verified image is written.

---
 rtl/inst_mem_loader_pkg.sv | 21 ++
 rtl/inst_mem_loader_if.sv | 13 +
 rtl/inst_mem_loader_byte_packer.sv | 32 +++
 rtl/inst_mem_loader.sv | 94 +++++++++
 4 files changed

// File: rtl/inst_mem_loader_pkg.sv
// Shared constants, FSM state encoding and the LEN decode for the program loader.
package inst_mem_loader_pkg;
    localparam int MAX_WORDS      = 64;
    localparam int BYTES_PER_WORD = 4;
    localparam int ADDR_W         = 8;
    localparam int WCNT_W         = 7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CHK  = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_e;

    // LEN 0 encodes a full image
    function automatic logic [WCNT_W-1:0] len_to_words(input logic [7:0] len);
        return (len == 8'd0) ? WCNT_W'(MAX_WORDS) : len[WCNT_W-1:0];
    endfunction
endpackage

// File: rtl/inst_mem_loader_if.sv
// Host byte stream in, instruction memory write port out.
interface inst_mem_loader_if;
    import inst_mem_loader_pkg::*;
    logic [7:0]        RX_DATA;
    logic              RX_VALID;
    logic              RX_READY;
    logic              MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [31:0]       MEM_DIN;

    modport slave  (input  RX_DATA, RX_VALID, output RX_READY, MEM_WE, MEM_ADDR, MEM_DIN);
    modport master (output RX_DATA, RX_VALID, input  RX_READY, MEM_WE, MEM_ADDR, MEM_DIN);
endinterface

// File: rtl/inst_mem_loader_byte_packer.sv
// Little-endian byte-to-word assembler; word-complete pulses with the 4th accepted byte.
module loader_byte_packer
    import inst_mem_loader_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        i_clr,
    input  logic        i_vld,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_done
);
    logic [1:0]  r_cnt;
    logic [23:0] r_sh;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
            r_sh  <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
            r_sh  <= '0;
        end else if (i_vld) begin
            r_cnt <= r_cnt + 2'd1;
            r_sh  <= {i_byte, r_sh[23:8]};
        end
    end

    // The 4th byte joins the word combinationally, so only three need storing
    assign o_word      = {i_byte, r_sh};
    assign o_word_done = i_vld && (r_cnt == 2'(BYTES_PER_WORD - 1));
endmodule

// File: rtl/inst_mem_loader.sv
// Framed byte-stream loader: writes instruction memory, holds CPU in reset until a verified image lands.
module inst_mem_loader
    import inst_mem_loader_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    inst_mem_loader_if.slave   bus,
    output logic               CPU_RST,
    output logic               DONE,
    output logic               ERR
);
    state_e              r_state, w_nxt;
    logic                r_rdy, r_we, r_cpu_rst, r_done, r_err;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_din;
    logic [WCNT_W-1:0]   r_n, r_wcnt;
    logic [7:0]          r_chk;
    logic                w_acc, w_len_ok, w_last, w_pk_vld, w_pk_clr, w_word_done;
    logic [31:0]         w_word;

    assign w_acc    = bus.RX_VALID && r_rdy;
    assign w_len_ok = bus.RX_DATA <= 8'(MAX_WORDS);
    assign w_pk_vld = w_acc && (r_state == ST_DATA);
    assign w_pk_clr = w_acc && w_len_ok && ((r_state == ST_LEN) || (r_state == ST_ERR));
    assign w_last   = (r_wcnt == r_n - WCNT_W'(1));

    loader_byte_packer u_pack (
        .CLK         (CLK),
        .RST         (RST),
        .i_clr       (w_pk_clr),
        .i_vld       (w_pk_vld),
        .i_byte      (bus.RX_DATA),
        .o_word      (w_word),
        .o_word_done (w_word_done)
    );

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            ST_IDLE:         w_nxt = ST_LEN;
            ST_LEN, ST_ERR:  if (w_acc) w_nxt = w_len_ok ? ST_DATA : ST_ERR;
            ST_DATA:         if (w_word_done && w_last) w_nxt = ST_CHK;
            ST_CHK:          if (w_acc) w_nxt = (bus.RX_DATA == r_chk) ? ST_DONE : ST_ERR;
            ST_DONE:         w_nxt = ST_DONE;
            default:         w_nxt = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with r_state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_rdy     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_din     <= '0;
            r_cpu_rst <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_n       <= '0;
            r_wcnt    <= '0;
            r_chk     <= '0;
        end else begin
            r_state   <= w_nxt;
            r_rdy     <= (w_nxt == ST_LEN) || (w_nxt == ST_DATA) ||
                         (w_nxt == ST_CHK) || (w_nxt == ST_ERR);
            r_cpu_rst <= (w_nxt != ST_DONE);
            r_done    <= (w_nxt == ST_DONE);
            r_err     <= (w_nxt == ST_ERR);
            r_we      <= w_word_done;
            if (w_pk_clr) begin
                r_n    <= len_to_words(bus.RX_DATA);
                r_wcnt <= '0;
                r_chk  <= '0;
            end
            if (w_pk_vld)
                r_chk <= r_chk ^ bus.RX_DATA;
            // Separate holding register: the next byte may land during the write cycle
            if (w_word_done) begin
                r_addr <= {r_wcnt[5:0], 2'b00};
                r_din  <= w_word;
                r_wcnt <= r_wcnt + WCNT_W'(1);
            end
        end
    end

    assign bus.RX_READY = r_rdy;
    assign bus.MEM_WE   = r_we;
    assign bus.MEM_ADDR = r_addr;
    assign bus.MEM_DIN  = r_din;
    assign CPU_RST      = r_cpu_rst;
    assign DONE         = r_done;
    assign ERR          = r_err;
endmodule
